// File: rtl/axi2mem_b_tracker_pkg.sv
// Shared types for the AXI write-response tracker: B response encodings,
// the tracker FSM state enum and a small response classification helper.
package axi2mem_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } state_e;

  // SLVERR and DECERR are the only encodings that flag an error.
  function automatic logic is_err_resp(resp_t r);
    return (r == RESP_SLVERR) || (r == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi2mem_b_tracker_if.sv
// Bundle of the AW gating and B response signals seen by the tracker.
// master: initiator/interconnect side, slave: tracker side.
interface axi2mem_b_tracker_if
  import axi2mem_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned USER_WIDTH = 6
) ();

  logic                  aw_valid;     // initiator -> tracker
  logic [ID_WIDTH-1:0]   aw_id;
  logic                  aw_ready;     // tracker -> initiator
  logic                  aw_valid_dn;  // tracker -> interconnect
  logic                  aw_ready_dn;  // interconnect -> tracker
  logic                  b_valid;
  resp_t                 b_resp;
  logic [ID_WIDTH-1:0]   b_id;
  logic [USER_WIDTH-1:0] b_user;
  logic                  b_ready;

  modport master (
    output aw_valid, aw_id, aw_ready_dn, b_valid, b_resp, b_id, b_user,
    input  aw_ready, aw_valid_dn, b_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_ready_dn, b_valid, b_resp, b_id, b_user,
    output aw_ready, aw_valid_dn, b_ready
  );

endinterface

// File: rtl/axi2mem_b_tracker_cnt.sv
// Saturating up/down counter, range 0..MAX_COUNT. inc and dec in the same
// cycle cancel out; the count never wraps in either direction.
module axi2mem_b_tracker_cnt #(
  parameter int unsigned MAX_COUNT = 8,
  localparam int unsigned CW       = $clog2(MAX_COUNT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          zero_o
);

  logic [CW-1:0] count_d, count_q;

  function automatic logic [CW-1:0] sat_step(logic [CW-1:0] c, logic inc, logic dec);
    if (inc && !dec && (c < CW'(MAX_COUNT))) return c + 1'b1;
    if (dec && !inc && (c != '0))            return c - 1'b1;
    return c;
  endfunction

  // Next count with saturation at both ends.
  always_comb begin
    count_d = sat_step(count_q, inc_i, dec_i);
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/axi2mem_b_tracker.sv
// AXI write-response tracker: counts outstanding AW transactions, gates new
// AWs at the outstanding limit or while draining, matches B responses,
// reports completions and sticky error / unexpected-response flags.
// Optional feature macro: AXI2MEM_B_TRACKER_PER_ID_EN adds one counter per
// AXI ID so that a B only matches an AW of the same ID.
module axi2mem_b_tracker
  import axi2mem_pkg::*;
#(
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned USER_WIDTH      = 6,
  parameter int unsigned MAX_OUTSTANDING = 8,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  aw_valid_i,
  input  logic [ID_WIDTH-1:0]   aw_id_i,
  output logic                  aw_ready_o,
  output logic                  aw_valid_o,
  input  logic                  aw_ready_i,
  input  logic                  b_valid_i,
  input  resp_t                 b_resp_i,
  input  logic [ID_WIDTH-1:0]   b_id_i,
  input  logic [USER_WIDTH-1:0] b_user_i,
  output logic                  b_ready_o,
  output logic                  done_valid_o,
  output logic [ID_WIDTH-1:0]   done_id_o,
  output resp_t                 done_resp_o,
  output logic [USER_WIDTH-1:0] done_user_o,
  output logic [CNT_W-1:0]      outstanding_o,
  output logic                  err_o,
  output logic                  unexpected_o,
  input  logic                  clear_i,
  input  logic                  drain_req_i,
  output logic                  drained_o
);

  state_e                state_q;
  logic                  drained_q;
  logic                  b_ready_q;
  logic [CNT_W-1:0]      total_cnt;
  logic                  total_zero;
  logic                  gate_open;
  logic                  aw_hs;
  logic                  b_hs;
  logic                  b_matched;

  logic                  done_valid_d, done_valid_q;
  logic [ID_WIDTH-1:0]   done_id_d,    done_id_q;
  resp_t                 done_resp_d,  done_resp_q;
  logic [USER_WIDTH-1:0] done_user_d,  done_user_q;
  logic                  err_d,        err_q;
  logic                  unexp_d,      unexp_q;

  // rst_ni is folded in so the downstream AW valid/ready are forced low
  // while reset is held, not just after the next clock edge.
  assign gate_open  = rst_ni && (state_q == ST_RUN) &&
                      (total_cnt < CNT_W'(MAX_OUTSTANDING));
  assign aw_valid_o = aw_valid_i && gate_open;
  assign aw_ready_o = aw_ready_i && gate_open;
  assign aw_hs      = aw_valid_o && aw_ready_i;
  assign b_hs       = b_valid_i && b_ready_q;

  axi2mem_b_tracker_cnt #(
    .MAX_COUNT (MAX_OUTSTANDING)
  ) u_total_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (aw_hs),
    .dec_i   (b_hs && b_matched),
    .count_o (total_cnt),
    .zero_o  (total_zero)
  );

`ifdef AXI2MEM_B_TRACKER_PER_ID_EN
  localparam int unsigned NUM_IDS = 1 << ID_WIDTH;

  logic [CNT_W-1:0]   id_cnt  [NUM_IDS];
  logic [NUM_IDS-1:0] id_zero;

  for (genvar g = 0; g < NUM_IDS; g++) begin : g_id_cnt
    axi2mem_b_tracker_cnt #(
      .MAX_COUNT (MAX_OUTSTANDING)
    ) u_id_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (aw_hs && (aw_id_i == ID_WIDTH'(g))),
      .dec_i   (b_hs && b_matched && (b_id_i == ID_WIDTH'(g))),
      .count_o (id_cnt[g]),
      .zero_o  (id_zero[g])
    );
  end

  assign b_matched = !id_zero[b_id_i];
`else
  assign b_matched = !total_zero;
`endif

  // Completion capture and sticky flags; a set in the same cycle as a clear wins.
  always_comb begin
    done_valid_d = b_hs;
    done_id_d    = done_id_q;
    done_resp_d  = done_resp_q;
    done_user_d  = done_user_q;
    if (b_hs) begin
      done_id_d   = b_id_i;
      done_resp_d = b_resp_i;
      done_user_d = b_user_i;
    end
    err_d   = err_q;
    unexp_d = unexp_q;
    if (clear_i) begin
      err_d   = 1'b0;
      unexp_d = 1'b0;
    end
    if (b_hs && is_err_resp(b_resp_i)) err_d   = 1'b1;
    if (b_hs && !b_matched)            unexp_d = 1'b1;
  end

  // Completion, flag and B-ready registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_resp_q  <= RESP_OKAY;
      done_user_q  <= '0;
      err_q        <= 1'b0;
      unexp_q      <= 1'b0;
      b_ready_q    <= 1'b0;
    end else begin
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      done_resp_q  <= done_resp_d;
      done_user_q  <= done_user_d;
      err_q        <= err_d;
      unexp_q      <= unexp_d;
      b_ready_q    <= 1'b1;
    end
  end

  // Drain FSM with drained_o registered alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_RUN;
      drained_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (drain_req_i) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!drain_req_i) begin
            state_q <= ST_RUN;
          end else if (total_zero) begin
            state_q   <= ST_DRAINED;
            drained_q <= 1'b1;
          end
        end
        ST_DRAINED: begin
          if (!drain_req_i) begin
            state_q   <= ST_RUN;
            drained_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_RUN;
          drained_q <= 1'b0;
        end
      endcase
    end
  end

  assign b_ready_o     = b_ready_q;
  assign done_valid_o  = done_valid_q;
  assign done_id_o     = done_id_q;
  assign done_resp_o   = done_resp_q;
  assign done_user_o   = done_user_q;
  assign outstanding_o = total_cnt;
  assign err_o         = err_q;
  assign unexpected_o  = unexp_q;
  assign drained_o     = drained_q;

endmodule

// File: doc/axi2mem_b_tracker.md
AXI2MEM_B_TRACKER -- requirements
Module: axi2mem_b_tracker

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4: AXI ID width.
REQ-002 SHALL have parameter USER_WIDTH, default 6: B user width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 8: total outstanding write limit, 1..255.
REQ-004 SHALL have ports, one clock, reset asynchronous active-low:
 clk_i  in  1  clock
 rst_ni  in  1  async active-low reset
 aw_valid_i  in  1  AW valid from initiator
 aw_id_i  in  ID_WIDTH  AW ID
 aw_ready_o  out  1  AW ready to initiator
 aw_valid_o  out  1  AW valid to interconnect
 aw_ready_i  in  1  AW ready from interconnect
 b_valid_i  in  1  B valid from interconnect
 b_resp_i  in  2  B response
 b_id_i  in  ID_WIDTH  B ID
 b_user_i  in  USER_WIDTH  B user
 b_ready_o  out  1  B ready
 done_valid_o  out  1  one-cycle completion pulse
 done_id_o / done_resp_o / done_user_o  out  ID_WIDTH / 2 / USER_WIDTH  completed response fields
 outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  total outstanding count
 err_o  out  1  sticky SLVERR/DECERR seen
 unexpected_o  out  1  sticky B with no matching AW
 clear_i  in  1  sync clear of err_o, unexpected_o
 drain_req_i  in  1  level drain request
 drained_o  out  1  drain complete

Function
REQ-005 SHALL gate AW: aw_valid_o = aw_valid_i & open, aw_ready_o = aw_ready_i & open; open = (state==RUN) & (outstanding_o < MAX_OUTSTANDING).
REQ-006 SHALL count AW handshake when aw_valid_o & aw_ready_i; B handshake when b_valid_i & b_ready_o.
REQ-007 SHALL drive b_ready_o = 1 in every cycle after reset release (registered, 0 during reset).
REQ-008 SHALL update outstanding_o next cycle: +1 on AW only, -1 on matched B only, unchanged on AW and matched B same cycle.
REQ-009 SHALL treat B as matched when outstanding count for its ID (per REQ-020) is nonzero; unmatched B SHALL NOT decrement and SHALL set unexpected_o next cycle.
REQ-010 SHALL register done_valid_o/done_id_o/done_resp_o/done_user_o one cycle after every B handshake, matched or not; fields hold last value when done_valid_o=0.
REQ-011 SHALL set err_o next cycle on B handshake with b_resp_i = 2'b10 or 2'b11; OKAY and EXOKAY SHALL NOT set it.
REQ-012 SHALL clear err_o/unexpected_o on clear_i; simultaneous set and clear SHALL leave flag set.
REQ-013 SHALL implement FSM RUN, DRAIN, DRAINED: RUN->DRAIN on drain_req_i=1; DRAIN->DRAINED when outstanding_o==0; DRAINED->RUN on drain_req_i=0; DRAIN->RUN on drain_req_i=0.
REQ-014 SHALL assert drained_o only in DRAINED; AW gated closed in DRAIN and DRAINED.
REQ-015 SHALL never let outstanding_o exceed MAX_OUTSTANDING nor wrap below 0.

Reset
REQ-016 SHALL on rst_ni=0 immediately reset: state RUN, all counters 0, b_ready_o 0, done_valid_o 0, done fields 0, err_o 0, unexpected_o 0, drained_o 0.
REQ-017 SHALL discard in-flight counts on reset mid-operation; B arriving after reset counts as unexpected.

Configuration
REQ-018 SHALL support macro AXI2MEM_B_TRACKER_PER_ID_EN.
REQ-019 Without macro SHALL keep only the total counter; B matched iff total > 0.
REQ-020 With macro SHALL also keep 2^ID_WIDTH per-ID counters, each width of outstanding_o; B matched iff counter[b_id_i] > 0; same-ID AW and matched B same cycle leave that counter unchanged.

Structure
REQ-021 SHALL place B response encodings (OKAY, EXOKAY, SLVERR, DECERR) and FSM state enum in package axi2mem_pkg.
REQ-022 SHALL use one sub-module axi2mem_b_tracker_cnt (saturating up/down counter with inc, dec, zero flag), instantiated for total and per ID.

Verification
REQ-023 Reset, then 3 AWs IDs 1,2,1 -> outstanding_o=3; B IDs 1,1,2 OKAY -> outstanding_o=0, three done pulses, err_o=0.
REQ-024 8 AWs without B -> aw_ready_o=0, aw_valid_o=0 on 9th; one B -> 9th AW accepted next cycle.
REQ-025 B with resp=2'b10 -> err_o=1; clear_i pulse -> err_o=0; clear with concurrent DECERR -> err_o stays 1.
REQ-026 With macro, AW ID 3 outstanding, B ID 5 -> unexpected_o=1, outstanding_o stays 1; without macro same stimulus -> outstanding_o=0, unexpected_o=0.
REQ-027 2 outstanding, drain_req_i=1 -> AW blocked; both B -> drained_o=1 next cycle; drain_req_i=0 -> RUN, AW open.
REQ-028 AW and matched B in same cycle at count 4 -> stays 4; rst_ni low mid-burst -> all outputs 0 asynchronously.
